// File: rtl/weight_update_arbiter_pkg.sv
// Shared types, learning constants and saturating weight arithmetic for the
// plasticity weight-update arbiter.
package weight_update_arbiter_pkg;

    localparam int          QDEPTH_DEF     = 4;
    localparam int          STARVE_LIM_DEF = 8;
    localparam logic [1:0]  W_INIT_DEF     = 2'd1;
    localparam int          NUM_W          = 16;
    localparam int          IDX_W          = 4;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_PROG,
        SRC_FORCED,
        SRC_LTP,
        SRC_QUEUE,
        SRC_BYPASS
    } wr_src_e;

    function automatic logic [1:0] sat_inc2(input logic [1:0] w);
        return (w == 2'd3) ? 2'd3 : w + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] w);
        return (w == 2'd0) ? 2'd0 : w - 2'd1;
    endfunction

endpackage

// File: rtl/weight_update_arbiter_ltd_fifo.sv
// Deferred-LTD queue: shift-compacted so the head is always slot 0, which lets
// invalidation remove arbitrary entries while preserving the order of the rest.
module ltd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int EW    = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [EW-1:0] push_data,
    input  logic          pop,
    input  logic          inval_en,
    input  logic [EW-1:0] inval_data,
    output logic [EW-1:0] head,
    output logic [CW-1:0] count,
    output logic          push_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem     [DEPTH];
    logic [EW-1:0] nxt_mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt_cnt;
    logic [CW-1:0] kept;

    // Pop and invalidate first, then append the push into whatever room is left.
    always_comb begin
        nxt_mem   = mem;
        kept      = '0;
        push_drop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt) && !(pop && (i == 0)) &&
                !(inval_en && (mem[i] == inval_data))) begin
                nxt_mem[kept[AW-1:0]] = mem[i];
                kept = kept + CW'(1);
            end
        end
        nxt_cnt = kept;
        if (push) begin
            if (kept == CW'(DEPTH)) begin
                push_drop = 1'b1;
            end else begin
                nxt_mem[kept[AW-1:0]] = push_data;
                nxt_cnt = kept + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= nxt_cnt;
            mem <= nxt_mem;
        end
    end

    assign head  = mem[0];
    assign count = cnt;

endmodule

// File: rtl/weight_update_arbiter.sv
// Single-port weight array arbiter: host programming, LTP and LTD compete for
// one write per cycle; LTD losers are deferred in a queue with anti-starvation.
module weight_update_arbiter
    import weight_update_arbiter_pkg::*;
#(
    parameter  int         QDEPTH     = QDEPTH_DEF,
    parameter  int         STARVE_LIM = STARVE_LIM_DEF,
    parameter  logic [1:0] W_INIT     = W_INIT_DEF,
    localparam int         CW         = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             prog_we,
    input  logic [IDX_W-1:0] prog_idx,
    input  logic [1:0]       prog_wdata,
    input  logic             ltp_req,
    input  logic [IDX_W-1:0] ltp_idx,
    output logic             ltp_ready,
    input  logic             ltd_req,
    input  logic [IDX_W-1:0] ltd_idx,
    input  logic [IDX_W-1:0] rd_idx_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic [1:0]       rd_data_a,
    output logic [1:0]       rd_data_b,
    output logic [2*NUM_W-1:0] weights,
    output logic [CW-1:0]    ltd_q_count,
    output logic             ltd_drop,
    output logic             busy
);

    localparam int AGE_W = $clog2(STARVE_LIM + 1);

    logic [1:0]       w [NUM_W];
    logic [AGE_W-1:0] age;
    logic [IDX_W-1:0] q_head;
    logic [CW-1:0]    q_count;
    logic             q_push;
    logic             q_pop;
    logic             q_inval;
    logic             q_drop;
    logic             starve_force;
    logic             head_inval;
    wr_src_e          src;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_val;

    assign busy         = (q_count != '0);
    assign starve_force = busy && (age >= AGE_W'(STARVE_LIM));
    assign ltp_ready    = ena && !prog_we && !starve_force;
    assign head_inval   = q_inval && busy && (q_head == prog_idx);

    // Write-source priority; a cancelled LTP/LTD pair leaves the slot unused.
    always_comb begin
        src     = SRC_NONE;
        q_push  = 1'b0;
        q_pop   = 1'b0;
        q_inval = 1'b0;
        if (ena && !rst) begin
            if (prog_we) begin
                src     = SRC_PROG;
                q_inval = 1'b1;
                q_push  = ltd_req && (ltd_idx != prog_idx);
            end else if (starve_force) begin
                src    = SRC_FORCED;
                q_pop  = 1'b1;
                q_push = ltd_req;
            end else if (ltp_req) begin
                if (!(ltd_req && (ltd_idx == ltp_idx))) begin
                    src    = SRC_LTP;
                    q_push = ltd_req;
                end
            end else if (busy) begin
                src    = SRC_QUEUE;
                q_pop  = 1'b1;
                q_push = ltd_req;
            end else if (ltd_req) begin
                src = SRC_BYPASS;
            end
        end
    end

    always_comb begin
        wr_idx = '0;
        wr_val = '0;
        case (src)
            SRC_PROG: begin
                wr_idx = prog_idx;
                wr_val = prog_wdata;
            end
            SRC_FORCED, SRC_QUEUE: begin
                wr_idx = q_head;
                wr_val = sat_dec2(w[q_head]);
            end
            SRC_LTP: begin
                wr_idx = ltp_idx;
                wr_val = sat_inc2(w[ltp_idx]);
            end
            SRC_BYPASS: begin
                wr_idx = ltd_idx;
                wr_val = sat_dec2(w[ltd_idx]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_W; i++) begin
                w[i] <= W_INIT;
            end
        end else if (src != SRC_NONE) begin
            w[wr_idx] <= wr_val;
        end
    end

    // A new head (after pop, invalidation of the head, or first fill) starts at age zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (ena) begin
            if (q_pop || head_inval || !busy) begin
                age <= '0;
            end else if (age < AGE_W'(STARVE_LIM)) begin
                age <= age + AGE_W'(1);
            end
        end
    end

    ltd_fifo #(
        .DEPTH (QDEPTH),
        .EW    (IDX_W)
    ) u_ltd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_data  (ltd_idx),
        .pop        (q_pop),
        .inval_en   (q_inval),
        .inval_data (prog_idx),
        .head       (q_head),
        .count      (q_count),
        .push_drop  (q_drop)
    );

    assign ltd_drop    = q_drop;
    assign ltd_q_count = q_count;
    assign rd_data_a   = w[rd_idx_a];
    assign rd_data_b   = w[rd_idx_b];

    for (genvar g = 0; g < NUM_W; g++) begin : g_flat
        assign weights[2*g +: 2] = w[g];
    end

endmodule

// File: tb/tb_weight_update_arbiter.sv
// Scenario bench for weight_update_arbiter with a behavioural queue model and
// a per-cycle scoreboard of post-edge weights and queue occupancy.
module tb_weight_update_arbiter;

    localparam int QD  = 4;
    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_idx = '0;
    logic [1:0]  prog_wdata = '0;
    logic        ltp_req = 1'b0;
    logic [3:0]  ltp_idx = '0;
    logic        ltp_ready;
    logic        ltd_req = 1'b0;
    logic [3:0]  ltd_idx = '0;
    logic [3:0]  rd_idx_a = '0;
    logic [3:0]  rd_idx_b = '0;
    logic [1:0]  rd_data_a;
    logic [1:0]  rd_data_b;
    logic [31:0] weights;
    logic [2:0]  ltd_q_count;
    logic        ltd_drop;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] w;
        int          cnt;
    } exp_t;

    exp_t       sb [$];
    logic [1:0] m_w [16];
    int         m_q [$];
    int         m_age;

    weight_update_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .prog_we     (prog_we),
        .prog_idx    (prog_idx),
        .prog_wdata  (prog_wdata),
        .ltp_req     (ltp_req),
        .ltp_idx     (ltp_idx),
        .ltp_ready   (ltp_ready),
        .ltd_req     (ltd_req),
        .ltd_idx     (ltd_idx),
        .rd_idx_a    (rd_idx_a),
        .rd_idx_b    (rd_idx_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .weights     (weights),
        .ltd_q_count (ltd_q_count),
        .ltd_drop    (ltd_drop),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [31:0] model_flat();
        logic [31:0] f;
        for (int i = 0; i < 16; i++) f[2*i +: 2] = m_w[i];
        return f;
    endfunction

    function automatic logic [1:0] inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic logic [1:0] dec2(input logic [1:0] v);
        return (v == 2'd0) ? v : v - 2'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_w[i] = 2'd1;
        m_q.delete();
        m_age = 0;
    endtask

    // One clock: pre-edge combinational checks, model step, post-edge scoreboard pop.
    task automatic tick();
        bit   force_pop, rdy, drop, popped, head_rm, was_empty;
        exp_t e;
        int   tmp [$];
        #1;
        force_pop = (m_q.size() != 0) && (m_age >= LIM);
        rdy = ena && !prog_we && !force_pop;
        drop = 0; popped = 0; head_rm = 0;
        checks++;
        if (ltp_ready !== rdy) begin
            errors++;
            $display("[TB] FAIL ltp_ready: got %b expected %b", ltp_ready, rdy);
        end
        checks++;
        if (rd_data_a !== m_w[rd_idx_a] || rd_data_b !== m_w[rd_idx_b]) begin
            errors++;
            $display("[TB] FAIL rd_data: got %0d/%0d expected %0d/%0d",
                     rd_data_a, rd_data_b, m_w[rd_idx_a], m_w[rd_idx_b]);
        end
        if (rst) begin
            model_reset();
        end else if (ena) begin
            was_empty = (m_q.size() == 0);
            if (prog_we) begin
                m_w[prog_idx] = prog_wdata;
                if (m_q.size() != 0 && m_q[0] == int'(prog_idx)) head_rm = 1;
                foreach (m_q[i]) if (m_q[i] != int'(prog_idx)) tmp.push_back(m_q[i]);
                m_q = tmp;
                if (ltd_req && ltd_idx != prog_idx) begin
                    if (m_q.size() < QD) m_q.push_back(int'(ltd_idx)); else drop = 1;
                end
            end else if (force_pop) begin
                m_w[m_q[0]] = dec2(m_w[m_q[0]]);
                void'(m_q.pop_front());
                popped = 1;
                if (ltd_req) m_q.push_back(int'(ltd_idx));
            end else if (ltp_req) begin
                if (!(ltd_req && ltd_idx == ltp_idx)) begin
                    m_w[ltp_idx] = inc2(m_w[ltp_idx]);
                    if (ltd_req) begin
                        if (m_q.size() < QD) m_q.push_back(int'(ltd_idx)); else drop = 1;
                    end
                end
            end else if (m_q.size() != 0) begin
                m_w[m_q[0]] = dec2(m_w[m_q[0]]);
                void'(m_q.pop_front());
                popped = 1;
                if (ltd_req) m_q.push_back(int'(ltd_idx));
            end else if (ltd_req) begin
                m_w[ltd_idx] = dec2(m_w[ltd_idx]);
            end
            if (popped || head_rm || was_empty) m_age = 0;
            else if (m_age < LIM) m_age++;
        end
        checks++;
        if (ltd_drop !== drop) begin
            errors++;
            $display("[TB] FAIL ltd_drop: got %b expected %b", ltd_drop, drop);
        end
        e.w = model_flat();
        e.cnt = m_q.size();
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (weights !== e.w) begin
            errors++;
            $display("[TB] FAIL weights: got %h expected %h", weights, e.w);
        end
        checks++;
        if (ltd_q_count !== 3'(e.cnt) || busy !== (e.cnt != 0)) begin
            errors++;
            $display("[TB] FAIL count/busy: got %0d/%b expected %0d/%b",
                     ltd_q_count, busy, e.cnt, e.cnt != 0);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; ena = 1; prog_we = 0; ltp_req = 0; ltd_req = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; ena = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        checks++;
        if (weights !== 32'h5555_5555 || ltd_q_count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h/%0d/%b expected 55555555/0/0",
                     weights, ltd_q_count, busy);
        end
        idle();
        tick();
    endtask

    task automatic test_ltp_saturate();
        logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        do_reset();
        ltp_req = 1; ltp_idx = 4'd5; rd_idx_a = 4'd5;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rd_data_a !== seq[k] || ltp_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ltp_sat[%0d]: got %0d/%b expected %0d/1",
                         k, rd_data_a, ltp_ready, seq[k]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_prog_priority();
        do_reset();
        prog_we = 1; prog_idx = 4'd3; prog_wdata = 2'd0;
        ltp_req = 1; ltp_idx = 4'd3;
        #1;
        checks++;
        if (ltp_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_blocks_ltp: got %b expected 0", ltp_ready);
        end
        tick();
        checks++;
        if (weights[7:6] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL prog_write: got %0d expected 0", weights[7:6]);
        end
        prog_we = 0;
        tick();
        checks++;
        if (weights[7:6] !== 2'd1) begin
            errors++;
            $display("[TB] FAIL ltp_after_prog: got %0d expected 1", weights[7:6]);
        end
        idle();
    endtask

    task automatic test_starvation();
        int drops = 0;
        int lows  = 0;
        int last  = -1;
        int gap_err = 0;
        do_reset();
        ltp_req = 1; ltp_idx = 4'd10;
        for (int k = 0; k < 6; k++) begin
            ltd_req = 1; ltd_idx = 4'(k);
            #1;
            if (ltd_drop === 1'b1) drops++;
            tick();
        end
        ltd_req = 0;
        checks++;
        if (drops != 2 || ltd_q_count !== 3'd4) begin
            errors++;
            $display("[TB] FAIL fill_drop: got %0d drops cnt %0d expected 2 drops cnt 4",
                     drops, ltd_q_count);
        end
        for (int n = 0; n < 40; n++) begin
            #1;
            if (ltp_ready !== 1'b1) begin
                lows++;
                if (last >= 0 && n - last != LIM + 1) gap_err++;
                last = n;
            end
            tick();
        end
        checks++;
        if (lows != 4 || gap_err != 0 || ltd_q_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL starve_pops: got %0d lows %0d gap errs cnt %0d expected 4/0/0",
                     lows, gap_err, ltd_q_count);
        end
        idle();
    endtask

    task automatic test_cancel();
        do_reset();
        prog_we = 1; prog_idx = 4'd7; prog_wdata = 2'd2;
        tick();
        prog_we = 0;
        ltp_req = 1; ltp_idx = 4'd7; ltd_req = 1; ltd_idx = 4'd7;
        tick();
        checks++;
        if (weights[15:14] !== 2'd2 || ltd_q_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL cancel: got %0d cnt %0d expected 2 cnt 0",
                     weights[15:14], ltd_q_count);
        end
        idle();
    endtask

    task automatic test_invalidate();
        logic [3:0] ids [3] = '{4'd2, 4'd9, 4'd2};
        do_reset();
        ltp_req = 1; ltp_idx = 4'd10;
        for (int k = 0; k < 3; k++) begin
            ltd_req = 1; ltd_idx = ids[k];
            tick();
        end
        idle();
        prog_we = 1; prog_idx = 4'd2; prog_wdata = 2'd3;
        tick();
        checks++;
        if (ltd_q_count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL inval_count: got %0d expected 1", ltd_q_count);
        end
        idle();
        repeat (2) tick();
        checks++;
        if (weights[19:18] !== 2'd0 || weights[5:4] !== 2'd3) begin
            errors++;
            $display("[TB] FAIL inval_result: got w9=%0d w2=%0d expected 0/3",
                     weights[19:18], weights[5:4]);
        end
    endtask

    task automatic test_bypass_and_enable();
        do_reset();
        ltd_req = 1; ltd_idx = 4'd4;
        repeat (2) tick();
        checks++;
        if (weights[9:8] !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bypass: got %0d busy %b expected 0 busy 0", weights[9:8], busy);
        end
        ena = 0; ltp_req = 1; ltp_idx = 4'd1; prog_we = 1; prog_idx = 4'd6; prog_wdata = 2'd3;
        #1;
        checks++;
        if (ltp_ready !== 1'b0 || ltd_drop !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ena_low: got ready %b drop %b expected 0/0", ltp_ready, ltd_drop);
        end
        repeat (2) tick();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ltp_req = 1; ltp_idx = 4'd10;
        for (int k = 0; k < 4; k++) begin
            ltd_req = 1; ltd_idx = 4'(k + 1);
            tick();
        end
        rst = 1; ltd_idx = 4'd12;
        #1;
        checks++;
        if (ltd_drop !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_drop: got %b expected 0", ltd_drop);
        end
        tick();
        idle();
        checks++;
        if (ltd_q_count !== 3'd0 || busy !== 1'b0 || weights !== 32'h5555_5555) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %0d/%b/%h expected 0/0/55555555",
                     ltd_q_count, busy, weights);
        end
        tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ltp_saturate();
        test_prog_priority();
        test_starvation();
        test_cancel();
        test_invalidate();
        test_bypass_and_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
